// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and latency constants for the BRAM read streamer
// BRAM_RD_OUTREG_EN selects the two-cycle (output-registered) BRAM read latency.
package bram_pkg;

`ifdef BRAM_RD_OUTREG_EN
   localparam int BRAM_RD_LAT = 2;
`else
   localparam int BRAM_RD_LAT = 1;
`endif

   // One slot per in-flight read plus the registered head and one spare.
   localparam int FIFO_DEPTH = BRAM_RD_LAT + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } rd_state_t;

endpackage

// File: rtl/bram_rd_streamer_if.sv
// rtl/bram_rd_streamer_if.sv - BRAM read port and output stream bundle
// master is the streamer side, slave is the RAM/consumer side.
interface bram_rd_streamer_if #(
   parameter int DW = 36,
   parameter int AW = 10
);
   logic          bram_en;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din;
   logic [DW-1:0] bram_dout;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;

   modport master (
      output bram_en, bram_we, bram_addr, bram_din, m_valid, m_data, m_last,
      input  bram_dout, m_ready
   );

   modport slave (
      input  bram_en, bram_we, bram_addr, bram_din, m_valid, m_data, m_last,
      output bram_dout, m_ready
   );
endinterface

// File: rtl/bram_rd_skid_fifo.sv
// rtl/bram_rd_skid_fifo.sv - small FIFO with a registered head for BRAM read data
// count includes the head; the writer guarantees it never pushes into a full FIFO.
module bram_rd_skid_fifo #(
   parameter int DW    = 36,
   parameter int DEPTH = 3,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          wlast,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic          last,
   output logic [CW-1:0] count
);
   localparam int SD  = DEPTH - 1;
   localparam int PW  = (SD > 1) ? $clog2(SD) : 1;
   localparam int SCW = $clog2(SD + 1);

   logic [DW:0]    mem [SD];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [SCW-1:0] scnt;
   logic           pop;
   logic           head_free;
   logic           from_mem;
   logic           bypass;
   logic           to_mem;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SD - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop       = valid && ready;
   assign head_free = !valid || pop;
   assign from_mem  = head_free && (scnt != '0);
   // An empty store lets a write land straight in the head, giving one-cycle write-to-valid.
   assign bypass    = head_free && (scnt == '0) && push;
   assign to_mem    = push && !bypass;
   assign count     = CW'(scnt) + CW'(valid);

   always_ff @(posedge clk) begin
      if (to_mem) begin
         mem[wr_ptr] <= {wlast, wdata};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         data   <= '0;
         last   <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         scnt   <= '0;
      end else begin
         if (head_free) begin
            if (from_mem) begin
               {last, data} <= mem[rd_ptr];
               valid        <= 1'b1;
               rd_ptr       <= ptr_inc(rd_ptr);
            end else if (push) begin
               {last, data} <= {wlast, wdata};
               valid        <= 1'b1;
            end else begin
               valid <= 1'b0;
            end
         end
         if (to_mem) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         scnt <= scnt + SCW'(to_mem) - SCW'(from_mem);
      end
   end

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(to_mem && !from_mem && (scnt == SCW'(SD))));

endmodule

// File: rtl/bram_rd_streamer.sv
// rtl/bram_rd_streamer.sv - burst reader for one BRAM port with credit-controlled stream output
// BRAM_RD_OUTREG_EN (via bram_pkg) switches read latency from 1 to 2 cycles.
module bram_rd_streamer
   import bram_pkg::*;
#(
   parameter int DW = 36,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   bram_rd_streamer_if.master bus
);
   localparam int LAT   = BRAM_RD_LAT;
   localparam int DEPTH = FIFO_DEPTH;
   localparam int CW    = $clog2(DEPTH + 1);

   rd_state_t     state;
   logic [AW-1:0] cur_addr;
   logic [AW:0]   remaining;
   logic [LAT-1:0] en_sr;
   logic [LAT-1:0] last_sr;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] inflight;
   logic [CW-1:0] credits;
   logic          issue;
   logic          issue_last;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + CW'(en_sr[i]);
      end
   end

   // Credits count the FIFO plus reads still in the RAM pipe, so the FIFO can never overflow.
   assign credits    = fifo_count + inflight;
   assign issue      = (state == ST_RUN) && (credits < CW'(DEPTH));
   assign issue_last = issue && (remaining == (AW+1)'(1));

   assign bus.bram_en   = issue;
   assign bus.bram_addr = cur_addr;
   assign bus.bram_we   = 1'b0;
   assign bus.bram_din  = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         cur_addr  <= '0;
         remaining <= '0;
         en_sr     <= '0;
         last_sr   <= '0;
      end else begin
         en_sr   <= LAT'({en_sr, issue});
         last_sr <= LAT'({last_sr, issue_last});
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cur_addr  <= base_addr;
                  remaining <= len;
                  busy      <= 1'b1;
                  state     <= (len == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  cur_addr  <= cur_addr + AW'(1);
                  remaining <= remaining - (AW+1)'(1);
                  if (issue_last) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.m_valid && bus.m_ready && bus.m_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            ST_DONE: begin
               // Entered with done already high after a burst; an empty burst raises it here.
               if (!done) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  done  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   bram_rd_skid_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (en_sr[LAT-1]),
      .wdata (bus.bram_dout),
      .wlast (last_sr[LAT-1]),
      .ready (bus.m_ready),
      .valid (bus.m_valid),
      .data  (bus.m_data),
      .last  (bus.m_last),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// tb/tb_bram_rd_streamer.sv - self-checking bench for bram_rd_streamer
// Honors BRAM_RD_OUTREG_EN for the RAM model latency and expected timing.
module tb_bram_rd_streamer;
   localparam int DW = 36;
   localparam int AW = 10;
`ifdef BRAM_RD_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DEPTH = LAT + 2;

   typedef struct {
      int base;
      int len;
      int mode;        // 0: ready high, 1: toggling, 2: random
      int poke;        // cycle of an extra start while busy, 0 = none
      int abort_beat;  // reset when this many beats are accepted, 0 = none
      int exp_first;   // -1 = no beat expected
      int exp_done;    // -1 = not checked
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy;
   logic          done;

   logic [DW-1:0] ram [1024];
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   bram_rd_streamer_if #(.DW(DW), .AW(AW)) bus ();

   bram_rd_streamer #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.bram_en) rd1 <= ram[bus.bram_addr];
      rd2 <= rd1;
   end
   assign bus.bram_dout = (LAT == 2) ? rd2 : rd1;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_bram_en"}, 64'(bus.bram_en), 64'd0);
      chk({tag, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
      chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
      chk({tag, "_m_data"}, 64'(bus.m_data), 64'd0);
      chk({tag, "_m_last"}, 64'(bus.m_last), 64'd0);
   endtask

   task automatic run_burst(input vec_t v);
      int issued, accepted, first_cyc, done_cyc, budget, exp_addr;
      logic prev_stall, aborted;
      logic [DW-1:0] prev_data;
      issued = 0; accepted = 0; first_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0; aborted = 1'b0; prev_data = '0;
      budget = 4 * v.len + 60;
      base_addr = AW'(v.base);
      len       = (AW+1)'(v.len);
      start     = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         start = (v.poke == cyc);
         if (v.poke == cyc) begin
            base_addr = ~AW'(v.base);
            len       = (AW+1)'(5);
         end
         case (v.mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = cyc[0];
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         if (bus.bram_en) begin
            chk("credit_limit", 64'((issued - accepted) < DEPTH), 64'd1);
            exp_addr = (v.base + issued) % 1024;
            chk("bram_addr", 64'(bus.bram_addr), 64'(exp_addr));
            chk("bram_we", 64'(bus.bram_we), 64'd0);
            issued++;
         end
         if (prev_stall) begin
            chk("hold_valid", 64'(bus.m_valid), 64'd1);
            chk("hold_data", 64'(bus.m_data), 64'(prev_data));
         end
         if (bus.m_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (accepted >= v.len) begin
               chk("extra_beat", 64'(accepted), 64'(v.len - 1));
            end else begin
               chk("m_data", 64'(bus.m_data), 64'(ram[(v.base + accepted) % 1024]));
               chk("m_last", 64'(bus.m_last), 64'(accepted == v.len - 1));
            end
            prev_stall = !bus.m_ready;
            prev_data  = bus.m_data;
            if (bus.m_ready) accepted++;
         end else begin
            prev_stall = 1'b0;
         end
         if (v.abort_beat > 0 && accepted == v.abort_beat) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("abort");
            aborted = 1'b1;
            break;
         end
         if (done) begin
            done_cyc = cyc;
            chk("busy_at_done", 64'(busy), 64'd0);
            break;
         end
         chk("busy", 64'(busy), 64'd1);
      end
      if (aborted) begin
         @(negedge clk);
         check_reset_outputs("abort_hold");
         rst_n = 1'b1;
         @(negedge clk);
         return;
      end
      checks++;
      if (done_cyc < 0) begin
         errors++;
         $display("FAIL timeout: done not seen within %0d cycles (base %0h len %0d)", budget, v.base, v.len);
      end
      chk("issued", 64'(issued), 64'(v.len));
      chk("beats", 64'(accepted), 64'(v.len));
      if (v.exp_first >= 0) chk("first_beat_cycle", 64'(first_cyc), 64'(v.exp_first));
      else chk("no_beats", 64'(first_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      if (v.exp_done >= 0) chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      vec_t r;
      int n;
      for (int i = 0; i < 1024; i++) begin
         ram[i] = (DW'($urandom) << 10) | DW'(i);
      end
      bus.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      vecs.push_back('{'h010,    4, 0, 0, 0, LAT + 2, LAT + 6});
      vecs.push_back('{'h020,    8, 1, 0, 0, LAT + 2, -1});
      vecs.push_back('{'h3FE,    4, 0, 0, 0, LAT + 2, LAT + 6});
      vecs.push_back('{'h100,    0, 0, 0, 0, -1,      2});
      vecs.push_back('{'h155, 1024, 0, 0, 0, LAT + 2, LAT + 2 + 1024});
      vecs.push_back('{'h200,   16, 0, 2, 0, LAT + 2, LAT + 18});
      vecs.push_back('{'h300,   10, 1, 0, 3, LAT + 2, -1});
      vecs.push_back('{'h304,    6, 0, 0, 0, LAT + 2, LAT + 8});
      vecs.push_back('{'h3F0,   40, 2, 0, 0, LAT + 2, -1});
      for (int i = 0; i < 10; i++) begin
         n = (i == 4) ? 0 : int'($urandom_range(1, 40));
         r = '{int'($urandom_range(0, 1023)), n, int'($urandom_range(0, 2)), 0, 0,
               (n > 0) ? LAT + 2 : -1, -1};
         if (r.mode == 0) r.exp_done = (n == 0) ? 2 : LAT + 2 + n;
         vecs.push_back(r);
      end

      foreach (vecs[i]) begin
         run_burst(vecs[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
